// File: rtl/filter_decimator.sv
// Boxcar decimator: averages each group of 2^LOG2_DEC samples and queues the
// results in a show-ahead FIFO with a valid/ready output and sticky overflow.
module filter_decimator #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LOG2_DEC   = 2,
    parameter int unsigned LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     Yn,
    input  logic                  in_en,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  overflow,
    input  logic                  clr_ovf
);
    localparam int unsigned AccW  = DATA_W + LOG2_DEC;
    localparam int unsigned Depth = 2 ** LOG2_DEPTH;

    logic [AccW-1:0]       acc_q, acc_d, sum;
    logic [LOG2_DEC-1:0]   phase_q, phase_d;
    logic [LOG2_DEPTH:0]   wr_q, wr_d, rd_q, rd_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_W-1:0]     mem_q [Depth];
    logic [DATA_W-1:0]     result;
    logic                  push, pop, full, empty, do_write, drop;

    assign sum    = acc_q + {{LOG2_DEC{1'b0}}, Yn};
    assign result = sum[AccW-1:LOG2_DEC];
    assign push   = in_en && (&phase_q);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[LOG2_DEPTH] != rd_q[LOG2_DEPTH]) &&
                   (wr_q[LOG2_DEPTH-1:0] == rd_q[LOG2_DEPTH-1:0]);
    assign pop   = !empty && m_ready;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        if (in_en) begin
            if (push) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
        if (do_write) wr_d = wr_q + 1'b1;
        if (pop)      rd_d = rd_q + 1'b1;
        if (clr_ovf)  ovf_d = 1'b0;
        if (drop)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            phase_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_q[LOG2_DEPTH-1:0]] <= result;
    end

    assign m_valid  = !empty;
    assign m_data   = empty ? '0 : mem_q[rd_q[LOG2_DEPTH-1:0]];
    assign count    = wr_q - rd_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator with hand-computed expected values.
module tb_filter_decimator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] Yn = '0;
    logic        in_en = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    filter_decimator dut (
        .clk      (clk),
        .reset    (reset),
        .Yn       (Yn),
        .in_en    (in_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        Yn    = v;
        in_en = 1'b1;
        @(posedge clk);
        #1;
        in_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);

        // 100 x4, m_ready held high
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'd100);
        check("t1_novalid_early", m_valid, 0);
        send(16'd100);
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, 100);
        check("t1_count1", count, 1);
        tick();
        check("t1_popped_valid", m_valid, 0);
        check("t1_popped_count", count, 0);
        check("t1_gated_data", m_data, 0);

        // Floor of 10/4
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        check("t2_floor", m_data, 2);
        tick();

        // Full-scale samples, no accumulator wrap
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        check("t3_fullscale", m_data, 16'hFFFF);
        tick();

        // Strobe toggled every cycle
        for (int i = 0; i < 8; i++) begin
            send(16'd7);
            if (i == 2) check("t4_none_before_4th", m_valid, 0);
            if (i == 3 || i == 7) begin
                check("t4_valid", m_valid, 1);
                check("t4_data", m_data, 7);
            end
            tick();
        end
        check("t4_drained", count, 0);

        // Back-pressure with overflow
        m_ready = 1'b0;
        for (int g = 1; g <= 5; g++) begin
            for (int i = 0; i < 4; i++) send(16'(10 * g));
            if (g == 4) check("t5_ovf_not_yet", overflow, 0);
        end
        check("t5_count_full", count, 4);
        check("t5_ovf_set", overflow, 1);
        m_ready = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            check("t5_pop_order", m_data, 10 * g);
            tick();
        end
        check("t5_empty_count", count, 0);
        check("t5_empty_valid", m_valid, 0);
        check("t5_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_ovf_cleared", overflow, 0);

        // Push into full FIFO with simultaneous pop: no drop
        do_reset();
        m_ready = 1'b0;
        for (int g = 11; g <= 14; g++)
            for (int i = 0; i < 4; i++) send(16'(g));
        check("t6_full", count, 4);
        for (int i = 0; i < 3; i++) send(16'd15);
        m_ready = 1'b1;
        send(16'd15);
        m_ready = 1'b0;
        check("t6_count_kept", count, 4);
        check("t6_no_ovf", overflow, 0);
        check("t6_head_next", m_data, 12);
        // Drop and clear on the same edge: set wins
        for (int i = 0; i < 3; i++) send(16'd16);
        clr_ovf = 1'b1;
        send(16'd16);
        clr_ovf = 1'b0;
        check("t6_set_wins", overflow, 1);
        check("t6_count_after_drop", count, 4);

        // Reset mid-group discards the partial sum
        do_reset();
        send(16'd50); send(16'd50);
        #2 reset = 1'b1;
        #1 check("t7_async_count", count, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send(16'd8);
        check("t7_no_early", m_valid, 0);
        send(16'd8);
        check("t7_single_count", count, 1);
        check("t7_result", m_data, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
